// File: rtl/ppe_rr_sched.sv
// Round-robin grant scheduler around a programmable priority encoder.
// Registers a one-hot grant and advances the pointer past each served requester.
module ppe #(
  parameter int W  = 16,
  parameter int LW = 4
) (
  input  logic [W-1:0]  req,
  input  logic [LW-1:0] p_enc,
  output logic [W-1:0]  gnt
);
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] hi;
  always_comb begin
    hi = req & ({W{1'b1}} << p_enc);
    if (|hi) gnt = hi & (~hi + ONE);
    else     gnt = req & (~req + ONE);
  end
endmodule

module ppe_rr_sched #(
  parameter int SCH_WIDTH   = 16,
  parameter int SCH_LOG_W   = 4,
  parameter int SCH_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SCH_WIDTH-1:0] Req,
  input  logic                 gnt_ack,
  input  logic                 ptr_load,
  input  logic [SCH_LOG_W-1:0] ptr_val,
  output logic [SCH_WIDTH-1:0] Gnt,
  output logic [SCH_LOG_W-1:0] Gnt_idx,
  output logic                 valid,
  output logic [SCH_LOG_W-1:0] ptr,
  output logic                 timeout_err
);
  localparam int TW = $clog2(SCH_TIMEOUT) + 1;
  localparam logic [TW-1:0] WD_LAST = TW'(SCH_TIMEOUT - 1);
  localparam logic [SCH_LOG_W-1:0] IONE = SCH_LOG_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;

  logic [SCH_WIDTH-1:0] gnt_nx, arb_req, win;
  logic [SCH_LOG_W-1:0] idx_nx, ptr_nx, arb_ptr, win_idx;
  logic [TW-1:0]        wd, wd_nx;
  logic                 to_nx, arb_en;
  logic                 served, revoked, timed;

  ppe #(.W(SCH_WIDTH), .LW(SCH_LOG_W)) u_ppe (
    .req   (arb_req),
    .p_enc (arb_ptr),
    .gnt   (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < SCH_WIDTH; i++)
      if (win[i]) win_idx = win_idx | SCH_LOG_W'(i);
  end

  assign served  = gnt_ack;
  assign revoked = !gnt_ack && !Req[Gnt_idx];
  assign timed   = !gnt_ack && Req[Gnt_idx] && (wd == WD_LAST);

  always_comb begin
    state_nx = state;
    gnt_nx   = Gnt;
    idx_nx   = Gnt_idx;
    ptr_nx   = ptr;
    wd_nx    = wd;
    to_nx    = 1'b0;
    arb_ptr  = ptr;
    arb_req  = Req;
    arb_en   = 1'b0;
    unique case (state)
      IDLE: arb_en = |Req;
      GRANT: begin
        if (served || revoked || timed) begin
          // departing requester is masked so it cannot win again at once
          to_nx   = timed;
          ptr_nx  = Gnt_idx + IONE;
          arb_ptr = Gnt_idx + IONE;
          arb_req = Req & ~Gnt;
          arb_en  = 1'b1;
        end else if (wd != {TW{1'b1}}) begin
          wd_nx = wd + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (ptr_load) begin
      ptr_nx  = ptr_val;
      arb_ptr = ptr_val;
    end
    if (arb_en) begin
      if (|win) begin
        gnt_nx   = win;
        idx_nx   = win_idx;
        wd_nx    = '0;
        state_nx = GRANT;
      end else begin
        gnt_nx   = '0;
        idx_nx   = '0;
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      Gnt         <= '0;
      Gnt_idx     <= '0;
      ptr         <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      Gnt         <= gnt_nx;
      Gnt_idx     <= idx_nx;
      ptr         <= ptr_nx;
      wd          <= wd_nx;
      timeout_err <= to_nx;
    end
  end

  assign valid = (state == GRANT);
endmodule

// File: tb/tb_ppe_rr_sched.sv
// Directed scoreboard bench for ppe_rr_sched at 8 requesters, timeout 4.
module tb_ppe_rr_sched;
  localparam int W  = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  Req = '0;
  logic          gnt_ack = 1'b0;
  logic          ptr_load = 1'b0;
  logic [LW-1:0] ptr_val = '0;
  logic [W-1:0]  Gnt;
  logic [LW-1:0] Gnt_idx;
  logic          valid;
  logic [LW-1:0] ptr;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int stp = 0;

  typedef struct {
    logic          v;
    logic [LW-1:0] idx;
    logic [LW-1:0] p;
    logic          to;
  } exp_t;
  exp_t q[$];

  ppe_rr_sched #(.SCH_WIDTH(W), .SCH_LOG_W(LW), .SCH_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Req         (Req),
    .gnt_ack     (gnt_ack),
    .ptr_load    (ptr_load),
    .ptr_val     (ptr_val),
    .Gnt         (Gnt),
    .Gnt_idx     (Gnt_idx),
    .valid       (valid),
    .ptr         (ptr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    logic [W-1:0] eg;
    eg = e.v ? (W'(1) << e.idx) : '0;
    chk({tag, ".valid"}, 32'(valid), 32'(e.v));
    chk({tag, ".gnt"}, 32'(Gnt), 32'(eg));
    chk({tag, ".idx"}, 32'(Gnt_idx), e.v ? 32'(e.idx) : 32'd0);
    chk({tag, ".ptr"}, 32'(ptr), 32'(e.p));
    chk({tag, ".to"}, 32'(timeout_err), 32'(e.to));
  endtask

  task automatic step(input logic [W-1:0] r, input logic a,
                      input logic pl, input logic [LW-1:0] pv,
                      input logic ev, input logic [LW-1:0] ei,
                      input logic [LW-1:0] ep, input logic eto);
    exp_t e;
    Req = r; gnt_ack = a; ptr_load = pl; ptr_val = pv;
    q.push_back('{ev, ei, ep, eto});
    @(posedge clk);
    #1;
    ptr_load = 1'b0;
    e = q.pop_front();
    stp++;
    chk_all($sformatf("s%0d", stp), e);
  endtask

  initial begin
    #12;
    chk_all("reset", '{1'b0, 3'd0, 3'd0, 1'b0});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // idle with no requests
    for (int i = 0; i < 5; i++) step(8'h00, 0, 0, 0, 0, 0, 0, 0);
    // immediate acks: 1,4,7,1,4
    step(8'b1001_0010, 1, 0, 0, 1, 3'd1, 3'd0, 0);
    step(8'b1001_0010, 1, 0, 0, 1, 3'd4, 3'd2, 0);
    step(8'b1001_0010, 1, 0, 0, 1, 3'd7, 3'd5, 0);
    step(8'b1001_0010, 1, 0, 0, 1, 3'd1, 3'd0, 0);
    step(8'b1001_0010, 1, 0, 0, 1, 3'd4, 3'd2, 0);
    step(8'h00, 1, 0, 0, 0, 0, 3'd5, 0);
    step(8'h00, 1, 0, 0, 0, 0, 3'd5, 0);
    // pointer load in idle, then wrap
    step(8'h00, 0, 1, 3'd6, 0, 0, 3'd6, 0);
    step(8'b0010_0001, 0, 0, 0, 1, 3'd0, 3'd6, 0);
    step(8'b0010_0001, 1, 0, 0, 1, 3'd5, 3'd1, 0);
    step(8'h00, 1, 0, 0, 0, 0, 3'd6, 0);
    // watchdog reclaim after 4 grant cycles
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd6, 0);
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd6, 0);
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd6, 0);
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd6, 0);
    step(8'b0000_1000, 0, 0, 0, 0, 0, 3'd4, 1);
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd4, 0);
    // ack on the timeout cycle wins
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd4, 0);
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd4, 0);
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd4, 0);
    step(8'b0000_1000, 1, 0, 0, 0, 0, 3'd4, 0);
    // revoke
    step(8'h00, 0, 1, 3'd2, 0, 0, 3'd2, 0);
    step(8'b0010_0100, 0, 0, 0, 1, 3'd2, 3'd2, 0);
    step(8'b0010_0000, 0, 0, 0, 1, 3'd5, 3'd3, 0);
    step(8'h00, 1, 0, 0, 0, 0, 3'd6, 0);
    // ack with simultaneous pointer load
    step(8'h00, 0, 1, 3'd3, 0, 0, 3'd3, 0);
    step(8'b0000_1000, 0, 0, 0, 1, 3'd3, 3'd3, 0);
    step(8'b1000_0011, 1, 1, 3'd0, 1, 3'd0, 3'd0, 0);
    step(8'b1000_0011, 1, 0, 0, 1, 3'd1, 3'd1, 0);
    // pointer load leaves outstanding grant alone
    step(8'b1000_0011, 0, 1, 3'd5, 1, 3'd1, 3'd5, 0);
    step(8'h00, 1, 0, 0, 0, 0, 3'd2, 0);
    // reset mid-grant
    step(8'b0000_0001, 0, 0, 0, 1, 3'd0, 3'd2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("midrst", '{1'b0, 3'd0, 3'd0, 1'b0});
    @(negedge clk) rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
